icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_icache_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
`timescale 1ns/1ps
// icache_ctrl: blocking instruction-cache controller with a single-block refill,
// LRU update strobe and tag/valid cache-maintenance operations.
module icache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int WORDS   = 8,
  parameter int BLOCK_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_va,
  input  logic [ADDR_W-1:0]  req_pa,
  output logic               resp_valid,
  output logic [31:0]        resp_ins,
  input  logic               flush,
  input  logic               cacop_valid,
  input  logic               cacop_op,
  input  logic [ADDR_W-1:0]  cacop_addr,
  output logic               cacop_done,
  output logic [ADDR_W-1:0]  ad,
  output logic [ADDR_W-1:0]  pa,
  output logic [1:0]         control_en,
  input  logic               hit,
  input  logic               rlru_to_cache,
  output logic               wlru_en_from_cache,
  output logic               select_way,
  output logic [BLOCK_W-1:0] r_data,
  input  logic [31:0]        ins,
  output logic               mem_arvalid,
  input  logic               mem_arready,
  output logic [ADDR_W-1:0]  mem_araddr,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rlast
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [1:0] I_LOAD      = 2'd0;
  localparam logic [1:0] I_WRITE_TAG = 2'd1;
  localparam logic [1:0] I_WRITE_V   = 2'd2;
  localparam logic [1:0] I_WRITE     = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, WRITE, CACOP} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  va_q, pa_q, cacop_addr_q;
  logic               cacop_op_q;
  logic               victim;
  logic               drop;
  logic [IDX_W-1:0]   cnt;
  logic [31:0]        buf_q [WORDS];
  logic               accept;
  logic               last_beat;

  assign last_beat = mem_rvalid && (mem_rlast || cnt == LAST_IDX);

  always_comb begin
    r_data = '0;
    for (int k = 0; k < WORDS; k++) r_data[32*k +: 32] = buf_q[k];
  end

  always_comb begin
    state_n            = state;
    accept             = 1'b0;
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_ins           = '0;
    wlru_en_from_cache = 1'b0;
    select_way         = 1'b0;
    control_en         = I_LOAD;
    ad                 = va_q;
    pa                 = pa_q;
    mem_arvalid        = 1'b0;
    mem_araddr         = {pa_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    case (state)
      IDLE: begin
        req_ready = !cacop_valid;
        if (cacop_valid) state_n = CACOP;
        else if (req_valid) begin
          accept  = 1'b1;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (flush) state_n = IDLE;
        else if (hit) begin
          resp_valid         = 1'b1;
          resp_ins           = ins;
          wlru_en_from_cache = 1'b1;
          req_ready          = !cacop_valid;
          // A new accept here keeps the pipeline streaming one hit per cycle.
          if (req_valid && !cacop_valid) accept = 1'b1;
          else state_n = IDLE;
        end else state_n = MISS_REQ;
      end
      MISS_REQ: begin
        mem_arvalid = 1'b1;
        if (mem_arready) state_n = REFILL;
      end
      REFILL: begin
        if (last_beat) state_n = WRITE;
      end
      WRITE: begin
        control_en = I_WRITE;
        select_way = victim;
        resp_valid = !(drop || flush);
        resp_ins   = buf_q[pa_q[OFF_W-1:2]];
        state_n    = IDLE;
      end
      CACOP: begin
        control_en = cacop_op_q ? I_WRITE_V : I_WRITE_TAG;
        ad         = cacop_addr_q;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      ad = req_va;
      pa = req_pa;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      va_q         <= '0;
      pa_q         <= '0;
      cacop_addr_q <= '0;
      cacop_op_q   <= 1'b0;
      cacop_done   <= 1'b0;
      victim       <= 1'b0;
      drop         <= 1'b0;
      cnt          <= '0;
      for (int k = 0; k < WORDS; k++) buf_q[k] <= '0;
    end else begin
      state      <= state_n;
      cacop_done <= (state == CACOP);
      if (accept) begin
        va_q <= req_va;
        pa_q <= req_pa;
      end
      if (state == IDLE && cacop_valid) begin
        cacop_addr_q <= cacop_addr;
        cacop_op_q   <= cacop_op;
      end
      if (state == LOOKUP && !flush && !hit) begin
        victim <= rlru_to_cache;
        drop   <= 1'b0;
      end
      // The refill always runs to completion; a flush only silences its response.
      if ((state == MISS_REQ || state == REFILL) && flush) drop <= 1'b1;
      if (state == MISS_REQ && mem_arready) cnt <= '0;
      if (state == REFILL && mem_rvalid) begin
        buf_q[cnt] <= mem_rdata;
        cnt        <= last_beat ? '0 : cnt + 1'b1;
      end
      if (state == WRITE) drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
`timescale 1ns/1ps
// tb_icache_ctrl: directed-vector bench for icache_ctrl covering hit, miss,
// back-to-back hits, flush during refill, cache ops and reset mid-refill.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [31:0]  req_va, req_pa;
  logic         resp_valid;
  logic [31:0]  resp_ins;
  logic         flush;
  logic         cacop_valid, cacop_op;
  logic [31:0]  cacop_addr;
  logic         cacop_done;
  logic [31:0]  ad, pa;
  logic [1:0]   control_en;
  logic         hit, rlru_to_cache;
  logic         wlru_en_from_cache, select_way;
  logic [255:0] r_data;
  logic [31:0]  ins;
  logic         mem_arvalid, mem_arready;
  logic [31:0]  mem_araddr;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         mem_rlast;

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] exp_block;

  icache_ctrl #(.ADDR_W(32), .WORDS(8), .BLOCK_W(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_va(req_va), .req_pa(req_pa),
    .resp_valid(resp_valid), .resp_ins(resp_ins),
    .flush(flush),
    .cacop_valid(cacop_valid), .cacop_op(cacop_op), .cacop_addr(cacop_addr),
    .cacop_done(cacop_done),
    .ad(ad), .pa(pa), .control_en(control_en),
    .hit(hit), .rlru_to_cache(rlru_to_cache),
    .wlru_en_from_cache(wlru_en_from_cache), .select_way(select_way),
    .r_data(r_data), .ins(ins),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge and return every input to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; req_va = '0; req_pa = '0; flush = 1'b0;
    cacop_valid = 1'b0; cacop_op = 1'b0; cacop_addr = '0;
    hit = 1'b0; rlru_to_cache = 1'b0; ins = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_va = '0; req_pa = '0; flush = 1'b0;
    cacop_valid = 1'b0; cacop_op = 1'b0; cacop_addr = '0;
    hit = 1'b0; rlru_to_cache = 1'b0; ins = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    #3;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_cacop_done", cacop_done, 0);
    checkOutput("rst_arvalid", mem_arvalid, 0);
    checkOutput("rst_wlru", wlru_en_from_cache, 0);
    checkOutput("rst_select_way", select_way, 0);
    checkOutput("rst_control_en", control_en, 0);
    applyStimulus();

    // Single hit: accept, response one cycle later.
    applyStimulus(); req_valid = 1; req_va = 32'h1000; req_pa = 32'h1000; #1;
    checkOutput("hit_accept_ready", req_ready, 1);
    checkOutput("hit_accept_ad", ad, 32'h1000);
    checkOutput("hit_accept_pa", pa, 32'h1000);
    checkOutput("hit_accept_resp", resp_valid, 0);
    applyStimulus(); hit = 1; ins = 32'hDEADBEEF; #1;
    checkOutput("hit_resp_valid", resp_valid, 1);
    checkOutput("hit_resp_ins", resp_ins, 32'hDEADBEEF);
    checkOutput("hit_wlru", wlru_en_from_cache, 1);
    checkOutput("hit_control_en", control_en, 0);
    applyStimulus(); #1;
    checkOutput("hit_after_resp", resp_valid, 0);
    checkOutput("hit_after_wlru", wlru_en_from_cache, 0);

    // Miss with victim way 1 and full 8-beat refill terminated by rlast.
    applyStimulus(); req_valid = 1; req_va = 32'h2014; req_pa = 32'h2014; #1;
    applyStimulus(); hit = 0; rlru_to_cache = 1; #1;
    checkOutput("miss_lookup_resp", resp_valid, 0);
    checkOutput("miss_lookup_wlru", wlru_en_from_cache, 0);
    checkOutput("miss_lookup_arvalid", mem_arvalid, 0);
    applyStimulus(); #1;
    checkOutput("miss_arvalid", mem_arvalid, 1);
    checkOutput("miss_araddr", mem_araddr, 32'h2000);
    checkOutput("miss_req_ready", req_ready, 0);
    applyStimulus(); mem_arready = 1; #1;
    checkOutput("miss_arvalid_held", mem_arvalid, 1);
    checkOutput("miss_araddr_held", mem_araddr, 32'h2000);
    exp_block = '0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(); mem_rvalid = 1; mem_rdata = 32'hA000_0000 + k; mem_rlast = (k == 7); #1;
      checkOutput("miss_beat_control_en", control_en, 0);
      checkOutput("miss_beat_resp", resp_valid, 0);
      exp_block[32*k +: 32] = 32'hA000_0000 + k;
    end
    applyStimulus(); #1;
    checkOutput("miss_write_control_en", control_en, 3);
    checkOutput("miss_write_select_way", select_way, 1);
    checkOutput("miss_write_ad", ad, 32'h2014);
    checkOutput("miss_write_resp_valid", resp_valid, 1);
    checkOutput("miss_write_resp_ins", resp_ins, 32'hA000_0005);
    checkOutput("miss_write_r_data", r_data, exp_block);
    applyStimulus(); #1;
    checkOutput("miss_after_control_en", control_en, 0);
    checkOutput("miss_after_select_way", select_way, 0);
    checkOutput("miss_after_resp", resp_valid, 0);

    // Four back-to-back hits.
    applyStimulus(); req_valid = 1; req_va = 32'h3000; req_pa = 32'h3000; #1;
    checkOutput("b2b_ready_0", req_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(); hit = 1; ins = 32'h1111_0000 + i;
      req_valid = (i < 4); req_va = 32'h3000 + 4 * i; req_pa = 32'h3000 + 4 * i; #1;
      checkOutput("b2b_resp_valid", resp_valid, 1);
      checkOutput("b2b_resp_ins", resp_ins, 32'h1111_0000 + i);
      checkOutput("b2b_ready", req_ready, 1);
      if (i < 4) checkOutput("b2b_ad", ad, 32'h3000 + 4 * i);
    end
    applyStimulus(); #1;
    checkOutput("b2b_after_resp", resp_valid, 0);

    // Flush during beat 3: refill completes on the counter, response suppressed.
    applyStimulus(); req_valid = 1; req_va = 32'h4008; req_pa = 32'h4008; #1;
    applyStimulus(); hit = 0; rlru_to_cache = 0; #1;
    applyStimulus(); mem_arready = 1; #1;
    checkOutput("flush_araddr", mem_araddr, 32'h4000);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(); mem_rvalid = 1; mem_rdata = 32'hB000_0000 + k; flush = (k == 3); #1;
      checkOutput("flush_beat_resp", resp_valid, 0);
    end
    applyStimulus(); #1;
    checkOutput("flush_write_control_en", control_en, 3);
    checkOutput("flush_write_select_way", select_way, 0);
    checkOutput("flush_write_resp", resp_valid, 0);
    checkOutput("flush_write_word2", r_data[95:64], 32'hB000_0002);
    applyStimulus(); #1;
    checkOutput("flush_after_control_en", control_en, 0);

    // Cache op (invalidate) has priority over a pending request.
    applyStimulus(); cacop_valid = 1; cacop_op = 1; cacop_addr = 32'h41;
    req_valid = 1; req_va = 32'h5000; req_pa = 32'h5000; #1;
    checkOutput("cacop_idle_ready", req_ready, 0);
    checkOutput("cacop_idle_control_en", control_en, 0);
    applyStimulus(); req_valid = 1; req_va = 32'h5000; req_pa = 32'h5000; #1;
    checkOutput("cacop_control_en", control_en, 2);
    checkOutput("cacop_ad", ad, 32'h41);
    checkOutput("cacop_ready", req_ready, 0);
    checkOutput("cacop_done_early", cacop_done, 0);
    applyStimulus(); req_valid = 1; req_va = 32'h5000; req_pa = 32'h5000; #1;
    checkOutput("cacop_done", cacop_done, 1);
    checkOutput("cacop_after_ready", req_ready, 1);
    checkOutput("cacop_after_ad", ad, 32'h5000);
    checkOutput("cacop_after_control_en", control_en, 0);
    applyStimulus(); hit = 1; ins = 32'h0000_0055; #1;
    checkOutput("cacop_req_resp", resp_valid, 1);
    checkOutput("cacop_req_ins", resp_ins, 32'h0000_0055);
    checkOutput("cacop_done_pulse", cacop_done, 0);

    // Cache op clearing the tag.
    applyStimulus(); cacop_valid = 1; cacop_op = 0; cacop_addr = 32'h80; #1;
    applyStimulus(); #1;
    checkOutput("cacop0_control_en", control_en, 1);
    checkOutput("cacop0_ad", ad, 32'h80);
    applyStimulus(); #1;
    checkOutput("cacop0_done", cacop_done, 1);

    // Reset asserted on refill beat 4; remaining beats must be ignored.
    applyStimulus(); req_valid = 1; req_va = 32'h6000; req_pa = 32'h6000; #1;
    applyStimulus(); hit = 0; rlru_to_cache = 1; #1;
    applyStimulus(); mem_arready = 1; #1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(); mem_rvalid = 1; mem_rdata = 32'hC000_0000 + k; #1;
    end
    applyStimulus(); mem_rvalid = 1; mem_rdata = 32'hC000_0004; rst = 1; #1;
    checkOutput("rstmid_arvalid", mem_arvalid, 0);
    checkOutput("rstmid_control_en", control_en, 0);
    checkOutput("rstmid_select_way", select_way, 0);
    checkOutput("rstmid_resp", resp_valid, 0);
    checkOutput("rstmid_ready", req_ready, 1);
    checkOutput("rstmid_cacop_done", cacop_done, 0);
    for (int k = 5; k < 8; k++) begin
      applyStimulus(); mem_rvalid = 1; mem_rdata = 32'hC000_0000 + k; mem_rlast = (k == 7); #1;
      checkOutput("rstmid_beat_control_en", control_en, 0);
      checkOutput("rstmid_beat_ready", req_ready, 1);
    end
    applyStimulus(); #1;
    checkOutput("rstmid_no_write", control_en, 0);
    checkOutput("rstmid_no_resp", resp_valid, 0);
    checkOutput("rstmid_no_arvalid", mem_arvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
